// File: rtl/ps2_symbol_in_pkg.sv
// Shared constants and scan-code lookup for the PS/2 symbol front end.
// Translates keyboard make codes into the cipher's 0-35 symbol alphabet.
package ps2_symbol_in_pkg;

   localparam int SYM_W   = 6;
   localparam int POS_W   = 3;
   localparam int SYM_MAX = 35;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef logic [1:0] frame_state_t;
   localparam frame_state_t ST_IDLE   = 2'd0;
   localparam frame_state_t ST_DATA   = 2'd1;
   localparam frame_state_t ST_PARITY = 2'd2;
   localparam frame_state_t ST_STOP   = 2'd3;

   // Returns {hit, symbol}; hit is 0 for codes outside the alphabet.
   function automatic logic [SYM_W:0] scan_to_sym(input logic [7:0] code);
      logic [SYM_W:0] r;
      r = '0;
      case (code)
         8'h45: r = {1'b1, 6'd0};   8'h16: r = {1'b1, 6'd1};
         8'h1E: r = {1'b1, 6'd2};   8'h26: r = {1'b1, 6'd3};
         8'h25: r = {1'b1, 6'd4};   8'h2E: r = {1'b1, 6'd5};
         8'h36: r = {1'b1, 6'd6};   8'h3D: r = {1'b1, 6'd7};
         8'h3E: r = {1'b1, 6'd8};   8'h46: r = {1'b1, 6'd9};
         8'h1C: r = {1'b1, 6'd10};  8'h32: r = {1'b1, 6'd11};
         8'h21: r = {1'b1, 6'd12};  8'h23: r = {1'b1, 6'd13};
         8'h24: r = {1'b1, 6'd14};  8'h2B: r = {1'b1, 6'd15};
         8'h34: r = {1'b1, 6'd16};  8'h33: r = {1'b1, 6'd17};
         8'h43: r = {1'b1, 6'd18};  8'h3B: r = {1'b1, 6'd19};
         8'h42: r = {1'b1, 6'd20};  8'h4B: r = {1'b1, 6'd21};
         8'h3A: r = {1'b1, 6'd22};  8'h31: r = {1'b1, 6'd23};
         8'h44: r = {1'b1, 6'd24};  8'h4D: r = {1'b1, 6'd25};
         8'h15: r = {1'b1, 6'd26};  8'h2D: r = {1'b1, 6'd27};
         8'h1B: r = {1'b1, 6'd28};  8'h2C: r = {1'b1, 6'd29};
         8'h3C: r = {1'b1, 6'd30};  8'h2A: r = {1'b1, 6'd31};
         8'h1D: r = {1'b1, 6'd32};  8'h22: r = {1'b1, 6'd33};
         8'h35: r = {1'b1, 6'd34};  8'h1A: r = {1'b1, 6'd35};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_symbol_in_frame_rx.sv
// PS/2 frame receiver: synchronizers, ps2_clk glitch filter, 11-bit frame FSM
// and an inactivity timeout that abandons partial frames.
module ps2_frame_rx
   import ps2_symbol_in_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [7:0]   rx_byte,
   output logic         byte_strobe,
   output logic         frame_err,
   output frame_state_t state
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic filt_q, filt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   frame_state_t state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d, byte_q, byte_d;
   logic par_ok_q, par_ok_d, strobe_q, strobe_d, err_q, err_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic fall;

   // The filtered level only moves after FILTER_LEN samples disagreeing with it in a row.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (clk_s2_q == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
         filt_d = clk_s2_q;
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
      fall = filt_q & ~filt_d;
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      byte_d   = byte_q;
      tmo_d    = tmo_q;
      strobe_d = 1'b0;
      err_d    = 1'b0;
      if (state_q == ST_IDLE || fall) begin
         tmo_d = '0;
      end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d  = ST_DATA;
                  bitcnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d  = {dat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_ok_d = ^{shift_q, dat_s2_q};
               state_d  = ST_STOP;
            end
            default: begin
               if (dat_s2_q && par_ok_q) begin
                  byte_d   = shift_q;
                  strobe_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_ok_q <= 1'b0;
         byte_q   <= '0;
         tmo_q    <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_ok_q <= par_ok_d;
         byte_q   <= byte_d;
         tmo_q    <= tmo_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   assign rx_byte     = byte_q;
   assign byte_strobe = strobe_q;
   assign frame_err   = err_q;
   assign state       = state_q;

endmodule

// File: rtl/ps2_symbol_in.sv
// Keyboard-to-cipher front end: decodes PS/2 make codes into symbols and
// advances the character position counter once per accepted symbol.
module ps2_symbol_in
   import ps2_symbol_in_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [SYM_W-1:0] sym,
   output logic [POS_W-1:0] pos,
   output logic             sym_valid,
   output logic             frame_err,
   output logic [1:0]       dbg_state
);

   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic [SYM_W:0] map;
   logic brk_q, brk_d, ext_q, ext_d, valid_q, valid_d;
   logic [SYM_W-1:0] sym_q, sym_d;
   logic [POS_W-1:0] pos_q, pos_d;

   ps2_frame_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_byte     (rx_byte),
      .byte_strobe (rx_strobe),
      .frame_err   (frame_err),
      .state       (dbg_state)
   );

   // A pending break swallows the next byte and any extended prefix with it.
   always_comb begin
      brk_d   = brk_q;
      ext_d   = ext_q;
      sym_d   = sym_q;
      pos_d   = pos_q;
      valid_d = 1'b0;
      map     = scan_to_sym(rx_byte);
      if (rx_strobe) begin
         if (rx_byte == SC_BREAK) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (ext_q) begin
            ext_d = 1'b0;
         end else if (map[SYM_W]) begin
            sym_d   = map[SYM_W-1:0];
            pos_d   = pos_q + 1'b1;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
         sym_q   <= '0;
         pos_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         brk_q   <= brk_d;
         ext_q   <= ext_d;
         sym_q   <= sym_d;
         pos_q   <= pos_d;
         valid_q <= valid_d;
      end
   end

   assign sym       = sym_q;
   assign pos       = pos_q;
   assign sym_valid = valid_q;

endmodule

// File: doc/ps2_symbol_in.md
PS2_SYMBOL_IN -- requirements
Module: ps2_symbol_in

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered ps2_clk level changes.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-007 sym  output  6  symbol code 0-35 (0-9 digits, 10-35 letters A-Z); feeds the cipher din.
REQ-008 pos  output  3  character position counter; pos[0] toggles once per accepted symbol; feeds the cipher pos.
REQ-009 sym_valid  output  1  one-cycle pulse per accepted symbol.
REQ-010 frame_err  output  1  one-cycle pulse per rejected frame (parity or stop error).

Function
REQ-011 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; ps2_clk SHALL then pass the FILTER_LEN glitch filter.
REQ-012 A frame bit SHALL be sampled from synchronized ps2_data on each falling edge of the filtered ps2_clk.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: sampled 0 -> DATA with bit count cleared; sampled 1 -> stay IDLE, no error.
REQ-015 DATA: 8 bits shifted in LSB first; after the 8th -> PARITY.
REQ-016 PARITY: sampled bit SHALL make data plus parity odd; record result -> STOP.
REQ-017 STOP: stop bit 1 and parity good -> byte delivered to decoder, IDLE; otherwise frame_err pulse, byte dropped, IDLE.
REQ-018 Outside IDLE, TIMEOUT cycles without a falling edge SHALL force IDLE with no byte and no frame_err.
REQ-019 Decoder: byte 0xF0 sets break flag; next delivered byte is discarded and clears break flag.
REQ-020 Decoder: byte 0xE0 sets ext flag; next delivered non-0xF0 byte is discarded and clears ext flag; E0 F0 xx sequence discards xx and clears both flags.
REQ-021 Make codes mapped: 45,16,1E,26,25,2E,36,3D,3E,46 -> 0-9; 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 10-35 (A-Z).
REQ-022 Unmapped make codes SHALL be ignored: no change to sym or pos, no pulse.
REQ-023 Mapped make code: sym, pos (+1) and sym_valid SHALL all update on the same clk edge, at most 2 cycles after the STOP sample edge.
REQ-024 pos SHALL wrap 7 -> 0; sym SHALL hold its value between symbols.
REQ-025 Typematic repeats of a held key SHALL each produce a new symbol.
REQ-026 Consecutive symbols are at least one PS/2 frame apart, so the downstream pos[0] edge detector always sees one toggle per symbol.

Reset
REQ-027 While reset is high: sym=0, pos=0, sym_valid=0, frame_err=0, FSM=IDLE, bit count, shift register, timeout counter and break/ext flags cleared; filter and synchronizers preset to 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the first complete frame is decoded normally.

Structure
REQ-029 Shared package: FSM state enum, scan-code constants (0xF0, 0xE0), SYM_MAX=35, symbol width 6, pos width 3.
REQ-030 Sub-module ps2_frame_rx (synchronizers, filter, frame FSM, timeout) SHALL output byte, byte_strobe, frame_err; decoder and pos counter live in ps2_symbol_in.

Verification
REQ-031 Frame 0x1C with correct parity -> sym=10, pos 0->1, one sym_valid pulse.
REQ-032 Sequence 0x16, 0xF0, 0x16 -> one symbol sym=1, pos=1; break code produces nothing.
REQ-033 Frame 0x45 with bad parity -> frame_err pulse, sym and pos unchanged.
REQ-034 Nine frames of 0x1A -> sym=35 each; pos steps 1..7, 0, 1; pos[0] toggles nine times.
REQ-035 Sequence E0 75 then E0 F0 75 -> no symbol, no pos change; following 0x3E -> sym=8.
REQ-036 Start bit plus 4 data bits, then idle for TIMEOUT+10 cycles, then full frame 0x24 -> no error pulse, sym=14.
